prog_loader: RTL and testbench

Boot-time program loader upstream of the `cpu` core. It receives a length-prefixed, checksummed byte stream over a valid/ready interface and writes the payload into program memory starting at address 0, holding the CPU in reset meanwhile. When the checksum matches, it releases the CPU. On a mismatch it latches an error and keeps the CPU held. A `restart` pulse re-arms the loader for a new image.

---
 rtl/prog_loader.sv | 120 ++++++++++++
 tb/tb_prog_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: accepts a length-prefixed, checksummed byte stream,
// writes the payload to program memory from address 0 and releases the CPU once verified.
module prog_loader #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int HI_W = ADDR_W - DATA_W;

    typedef enum logic [2:0] {
        ST_LEN_HI,
        ST_LEN_LO,
        ST_LOAD,
        ST_CHK,
        ST_RUN,
        ST_ERR
    } state_t;

    state_t            state, state_nxt;
    logic [HI_W-1:0]   len_hi;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] remaining;
    logic [DATA_W-1:0] sum;
    logic              accept;

    // Status outputs come straight from the state register, never from in_valid.
    assign in_ready = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
                      (state == ST_LOAD)   || (state == ST_CHK);
    assign cpu_hold = (state != ST_RUN);
    assign done     = (state == ST_RUN);
    assign err      = (state == ST_ERR);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_LEN_HI;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LEN_HI: begin
                if (accept) begin
                    if (in_data[DATA_W-1:HI_W] != '0) state_nxt = ST_ERR;
                    else                              state_nxt = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    if ({len_hi, in_data} == '0) state_nxt = ST_CHK;
                    else                         state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept && remaining == ADDR_W'(1)) state_nxt = ST_CHK;
            end
            ST_CHK: begin
                if (accept) begin
                    if (in_data == sum) state_nxt = ST_RUN;
                    else                state_nxt = ST_ERR;
                end
            end
            ST_RUN, ST_ERR: begin
                if (restart) state_nxt = ST_LEN_HI;
            end
            default: state_nxt = ST_LEN_HI;
        endcase
    end

    // mem_addr/mem_wdata only move on a write, so they hold the last written location.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_hi    <= '0;
            wr_ptr    <= '0;
            remaining <= '0;
            sum       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr    <= 1'b0;
        end else begin
            mem_wr <= 1'b0;
            if (accept) begin
                case (state)
                    ST_LEN_HI: len_hi <= in_data[HI_W-1:0];
                    ST_LEN_LO: begin
                        wr_ptr    <= '0;
                        sum       <= '0;
                        remaining <= {len_hi, in_data};
                    end
                    ST_LOAD: begin
                        mem_addr  <= wr_ptr;
                        mem_wdata <= in_data;
                        mem_wr    <= 1'b1;
                        sum       <= sum + in_data;
                        wr_ptr    <= wr_ptr + ADDR_W'(1);
                        remaining <= remaining - ADDR_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued as payload
// bytes are driven and popped as the loader strobes mem_wr.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        restart;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wr;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [20:0] exp_q[$];
    logic [7:0]  pl[$];
    logic [20:0] mon_e;

    prog_loader #(.ADDR_W(13), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .restart(restart), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wr(mem_wr), .cpu_hold(cpu_hold),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Every strobe must match the oldest queued write; an empty queue means a stray write.
    always @(negedge clk) begin
        if (reset && mem_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(mon_e[20:8]));
                chk("wr_data", 32'(mem_wdata), 32'(mon_e[7:0]));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit rs);
        int w;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        restart  = rs;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        restart  = 1'b0;
    endtask

    task automatic load_image(input int n, input logic [7:0] csum, input bit toggle, input bit rs_in_load);
        send_byte(8'(n >> 8), 1'b0);
        send_byte(8'(n), 1'b0);
        for (int i = 0; i < n; i++) begin
            if (toggle && $urandom_range(0, 1) == 1) idle();
            exp_q.push_back({13'(i), pl[i]});
            send_byte(pl[i], rs_in_load);
        end
        send_byte(csum, 1'b0);
        idle();
    endtask

    task automatic status(input string tag, input logic r, input logic h, input logic d, input logic e);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(r));
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_err"}, 32'(err), 32'(e));
        chk({tag, "_pending_wr"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_restart(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        restart  = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        chk({tag, "_rst_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_rst_done"}, 32'(done), 32'd0);
        chk({tag, "_rst_err"}, 32'(err), 32'd0);
        chk({tag, "_rst_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        restart  = 1'b0;
        in_data  = 8'h00;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Normal three-byte image
        pl = '{8'h11, 8'h22, 8'h33};
        load_image(3, 8'h66, 1'b0, 1'b0);
        status("normal", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("normal_last_addr", 32'(mem_addr), 32'd2);

        // Bad checksum
        do_restart("badcs");
        load_image(3, 8'h67, 1'b0, 1'b0);
        status("badcs", 1'b0, 1'b1, 1'b0, 1'b1);

        // Zero length
        do_restart("zero");
        pl.delete();
        load_image(0, 8'h00, 1'b0, 1'b0);
        status("zero", 1'b0, 1'b0, 1'b1, 1'b0);

        // Bad length high byte
        do_restart("badlen");
        send_byte(8'h20, 1'b0);
        idle();
        status("badlen", 1'b0, 1'b1, 1'b0, 1'b1);

        // 256 bytes of 0xFF with random gaps in in_valid
        do_restart("bp");
        pl.delete();
        for (int i = 0; i < 256; i++) pl.push_back(8'hFF);
        load_image(256, 8'h00, 1'b1, 1'b0);
        status("bp", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp_last_addr", 32'(mem_addr), 32'd255);

        // Restart from RUN, with restart also pulsed while loading
        do_restart("rs");
        pl = '{8'hAB};
        load_image(1, 8'hAB, 1'b0, 1'b1);
        status("rs", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rs_last_addr", 32'(mem_addr), 32'd0);

        // Async reset after two of three payload bytes
        do_restart("mid");
        pl = '{8'h11, 8'h22, 8'h33};
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        exp_q.push_back({13'd0, 8'h11});
        send_byte(8'h11, 1'b0);
        exp_q.push_back({13'd1, 8'h22});
        send_byte(8'h22, 1'b0);
        #2;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_mem_wr", 32'(mem_wr), 32'd0);
        chk("mid_mem_addr", 32'(mem_addr), 32'd0);
        chk("mid_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        chk("mid_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_err", 32'(err), 32'd0);
        exp_q.delete();
        #1;
        reset = 1'b1;
        load_image(3, 8'h66, 1'b0, 1'b0);
        status("reload", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("reload_last_addr", 32'(mem_addr), 32'd2);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
